// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: opcodes, hazard FSM state encoding and counter width.
package pipeline_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_MUL = 4'h6;
  localparam logic [3:0] OP_BEQ = 4'h8;

  localparam int CNT_W = 3;

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_MUL_BUSY   = 2'd2
  } state_t;

endpackage

// File: rtl/pipeline_hazard_ctrl_detect.sv
// Load-use compare between the ID sources and the EX load destination; purely combinational.
import pipeline_pkg::*;

module hazard_detect #(
  parameter int REG_ADDR_W = 3
) (
  input  logic [3:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [3:0]            ex_opcode,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  output logic                  load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = id_uses_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit = id_uses_rs2 && (id_rs2 == ex_rd);

  // A bubble sitting in ID reads nothing, so it can never wait on a load.
  assign load_use = (ex_opcode == OP_LD) && (id_opcode != OP_NOP) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline; outputs combinational from state, counter and inputs.
// Optional HAZARD_PERF_EN adds saturating stall/flush event counters.
import pipeline_pkg::*;

module pipeline_hazard_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int LOAD_LAT   = 1,
  parameter int MUL_CYCLES = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [3:0]            id_opcode,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_uses_rs1,
  input  logic                  id_uses_rs2,
  input  logic [3:0]            ex_opcode,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  branch_taken,
  output logic                  pc_write,
  output logic                  if_id_write,
  output logic                  if_id_flush,
  output logic                  id_ex_write,
  output logic                  id_ex_bubble,
  output logic                  ex_mem_bubble,
  output logic [1:0]            ctrl_state
`ifdef HAZARD_PERF_EN
  ,
  output logic [15:0]           stall_count,
  output logic [15:0]           flush_count
`endif
);

  localparam logic [CNT_W-1:0] MUL_INIT  = CNT_W'(MUL_CYCLES - 2);
  localparam logic [CNT_W-1:0] LOAD_INIT = CNT_W'((LOAD_LAT > 1) ? (LOAD_LAT - 2) : 0);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             load_use;
  logic             mul_start;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_detect (
    .id_opcode   (id_opcode),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs1 (id_uses_rs1),
    .id_uses_rs2 (id_uses_rs2),
    .ex_opcode   (ex_opcode),
    .ex_rd       (ex_rd),
    .load_use    (load_use)
  );

  assign mul_start = (ex_opcode == OP_MUL);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_RUN;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_LOAD_STALL, ST_MUL_BUSY: begin
        if (cnt == '0) state_nxt = ST_RUN;
        else           cnt_nxt   = cnt - CNT_W'(1);
      end
      default: begin
        // Unused encoding 3 falls back into RUN here.
        state_nxt = ST_RUN;
        if (branch_taken) begin
          state_nxt = ST_RUN;
        end else if (mul_start) begin
          state_nxt = ST_MUL_BUSY;
          cnt_nxt   = MUL_INIT;
        end else if (load_use && (LOAD_LAT > 1)) begin
          state_nxt = ST_LOAD_STALL;
          cnt_nxt   = LOAD_INIT;
        end
      end
    endcase
  end

  always_comb begin
    pc_write      = 1'b1;
    if_id_write   = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_write   = 1'b1;
    id_ex_bubble  = 1'b0;
    ex_mem_bubble = 1'b0;
    case (state)
      ST_LOAD_STALL: begin
        pc_write     = 1'b0;
        if_id_write  = 1'b0;
        id_ex_bubble = 1'b1;
      end
      ST_MUL_BUSY: begin
        pc_write      = 1'b0;
        if_id_write   = 1'b0;
        id_ex_write   = 1'b0;
        // Final MUL cycle lets the product through to EX/MEM.
        ex_mem_bubble = (cnt != '0);
      end
      default: begin
        if (branch_taken) begin
          if_id_flush  = 1'b1;
          id_ex_bubble = 1'b1;
        end else if (mul_start) begin
          pc_write      = 1'b0;
          if_id_write   = 1'b0;
          id_ex_write   = 1'b0;
          ex_mem_bubble = 1'b1;
        end else if (load_use) begin
          pc_write     = 1'b0;
          if_id_write  = 1'b0;
          id_ex_bubble = 1'b1;
        end
      end
    endcase
  end

  assign ctrl_state = state;

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!pc_write && (stall_count != 16'hFFFF)) stall_count <= stall_count + 16'd1;
      if (if_id_flush && (flush_count != 16'hFFFF)) flush_count <= flush_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: instance a uses LOAD_LAT=1, instance b LOAD_LAT=3.
module tb_pipeline_hazard_ctrl;

  localparam logic [3:0] NOP = 4'h0;
  localparam logic [3:0] LD  = 4'h2;
  localparam logic [3:0] MUL = 4'h6;
  localparam logic [3:0] BEQ = 4'h8;

  // Output vector: {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble, ctrl_state}
  localparam logic [7:0] E_RUN   = 8'b110100_00;
  localparam logic [7:0] E_LDRUN = 8'b000110_00;
  localparam logic [7:0] E_LDST  = 8'b000110_01;
  localparam logic [7:0] E_MUL0  = 8'b000001_00;
  localparam logic [7:0] E_MULB  = 8'b000001_10;
  localparam logic [7:0] E_MULL  = 8'b000000_10;
  localparam logic [7:0] E_BR    = 8'b111110_00;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] id_opcode = 4'h1;
  logic [2:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic       id_uses_rs1 = 1'b0, id_uses_rs2 = 1'b0, branch_taken = 1'b0;
  logic [3:0] ex_opcode = 4'h0;

  logic pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_bubble_a, ex_mem_bubble_a;
  logic pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_bubble_b, ex_mem_bubble_b;
  logic [1:0] ctrl_state_a, ctrl_state_b;
`ifdef HAZARD_PERF_EN
  logic [15:0] stall_count_a, flush_count_a, stall_count_b, flush_count_b;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pipeline_hazard_ctrl #(.REG_ADDR_W(3), .LOAD_LAT(1), .MUL_CYCLES(4)) dut_a (
    .clock(clock), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .pc_write(pc_write_a), .if_id_write(if_id_write_a),
    .if_id_flush(if_id_flush_a), .id_ex_write(id_ex_write_a), .id_ex_bubble(id_ex_bubble_a),
    .ex_mem_bubble(ex_mem_bubble_a), .ctrl_state(ctrl_state_a)
`ifdef HAZARD_PERF_EN
    , .stall_count(stall_count_a), .flush_count(flush_count_a)
`endif
  );

  pipeline_hazard_ctrl #(.REG_ADDR_W(3), .LOAD_LAT(3), .MUL_CYCLES(4)) dut_b (
    .clock(clock), .reset(reset), .id_opcode(id_opcode), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2), .ex_opcode(ex_opcode), .ex_rd(ex_rd),
    .branch_taken(branch_taken), .pc_write(pc_write_b), .if_id_write(if_id_write_b),
    .if_id_flush(if_id_flush_b), .id_ex_write(id_ex_write_b), .id_ex_bubble(id_ex_bubble_b),
    .ex_mem_bubble(ex_mem_bubble_b), .ctrl_state(ctrl_state_b)
`ifdef HAZARD_PERF_EN
    , .stall_count(stall_count_b), .flush_count(flush_count_b)
`endif
  );

  function automatic logic [7:0] outs_a();
    return {pc_write_a, if_id_write_a, if_id_flush_a, id_ex_write_a, id_ex_bubble_a, ex_mem_bubble_a, ctrl_state_a};
  endfunction

  function automatic logic [7:0] outs_b();
    return {pc_write_b, if_id_write_b, if_id_flush_b, id_ex_write_b, id_ex_bubble_b, ex_mem_bubble_b, ctrl_state_b};
  endfunction

  task automatic drive(input logic [3:0] eop, input logic [2:0] erd, input logic [2:0] r1,
                       input logic u1, input logic [2:0] r2, input logic u2, input logic br);
    ex_opcode = eop; ex_rd = erd; id_rs1 = r1; id_uses_rs1 = u1;
    id_rs2 = r2; id_uses_rs2 = u2; branch_taken = br;
  endtask

  task automatic idle();
    drive(NOP, 3'd0, 3'd1, 1'b0, 3'd2, 1'b0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      checks++; if (outs_a() !== E_RUN) begin errors++; $display("FAIL reset_a c%0d got %b exp %b", c, outs_a(), E_RUN); end
      checks++; if (outs_b() !== E_RUN) begin errors++; $display("FAIL reset_b c%0d got %b exp %b", c, outs_b(), E_RUN); end
`ifdef HAZARD_PERF_EN
      checks++; if ({stall_count_a, flush_count_a} !== 32'd0) begin errors++; $display("FAIL reset_perf got %h exp 0", {stall_count_a, flush_count_a}); end
`endif
      next_cycle();
    end
  endtask

  task automatic test_no_hazard();
    drive(NOP, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 1'b0);
    @(negedge clock);
    checks++; if (outs_a() !== E_RUN) begin errors++; $display("FAIL nop_ex got %b exp %b", outs_a(), E_RUN); end
    next_cycle();
    drive(BEQ, 3'd3, 3'd3, 1'b1, 3'd3, 1'b1, 1'b0);
    @(negedge clock);
    checks++; if (outs_a() !== E_RUN) begin errors++; $display("FAIL beq_not_taken got %b exp %b", outs_a(), E_RUN); end
    next_cycle();
  endtask

  task automatic test_load_use();
    logic [7:0] exp_b [4];
    exp_b[0] = E_LDRUN; exp_b[1] = E_LDST; exp_b[2] = E_LDST; exp_b[3] = E_RUN;
    // rs2 hit, then the same with rs1 hit on a different register.
    for (int v = 0; v < 2; v++) begin
      if (v == 0) drive(LD, 3'd3, 3'd5, 1'b1, 3'd3, 1'b1, 1'b0);
      else        drive(LD, 3'd6, 3'd6, 1'b1, 3'd0, 1'b0, 1'b0);
      for (int c = 0; c < 4; c++) begin
        @(negedge clock);
        checks++; if (outs_a() !== ((c == 0) ? E_LDRUN : E_RUN)) begin errors++; $display("FAIL ld_a v%0d c%0d got %b exp %b", v, c, outs_a(), ((c == 0) ? E_LDRUN : E_RUN)); end
        checks++; if (outs_b() !== exp_b[c]) begin errors++; $display("FAIL ld_b v%0d c%0d got %b exp %b", v, c, outs_b(), exp_b[c]); end
        next_cycle();
        idle();
      end
    end
    drive(LD, 3'd3, 3'd5, 1'b1, 3'd3, 1'b0, 1'b0);
    @(negedge clock);
    checks++; if (outs_b() !== E_RUN) begin errors++; $display("FAIL ld_no_use_rs2 got %b exp %b", outs_b(), E_RUN); end
    next_cycle();
    drive(LD, 3'd3, 3'd3, 1'b0, 3'd4, 1'b1, 1'b0);
    @(negedge clock);
    checks++; if (outs_a() !== E_RUN) begin errors++; $display("FAIL ld_no_use_rs1 got %b exp %b", outs_a(), E_RUN); end
    next_cycle();
    idle();
  endtask

  task automatic test_mul();
    logic [7:0] exp [5];
    exp[0] = E_MUL0; exp[1] = E_MULB; exp[2] = E_MULB; exp[3] = E_MULL; exp[4] = E_RUN;
    reset = 1'b1;
    idle();
    next_cycle();
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      // Branch and load-use inputs in MUL_BUSY must be ignored.
      if (c == 2)      drive(MUL, 3'd3, 3'd3, 1'b1, 3'd3, 1'b1, 1'b1);
      else if (c < 4)  drive(MUL, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
      else             idle();
      @(negedge clock);
      checks++; if (outs_a() !== exp[c]) begin errors++; $display("FAIL mul_a c%0d got %b exp %b", c, outs_a(), exp[c]); end
      checks++; if (outs_b() !== exp[c]) begin errors++; $display("FAIL mul_b c%0d got %b exp %b", c, outs_b(), exp[c]); end
`ifdef HAZARD_PERF_EN
      checks++; if (stall_count_a !== 16'(c)) begin errors++; $display("FAIL mul_stall_count c%0d got %0d exp %0d", c, stall_count_a, c); end
`endif
      next_cycle();
    end
  endtask

  task automatic test_branch();
    drive(LD, 3'd3, 3'd5, 1'b0, 3'd3, 1'b1, 1'b1);
    @(negedge clock);
    checks++; if (outs_a() !== E_BR) begin errors++; $display("FAIL br_over_ld_a got %b exp %b", outs_a(), E_BR); end
    checks++; if (outs_b() !== E_BR) begin errors++; $display("FAIL br_over_ld_b got %b exp %b", outs_b(), E_BR); end
    next_cycle();
    drive(MUL, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    @(negedge clock);
    checks++; if (outs_a() !== E_BR) begin errors++; $display("FAIL br_over_mul got %b exp %b", outs_a(), E_BR); end
    next_cycle();
    idle();
    @(negedge clock);
    checks++; if (outs_b() !== E_RUN) begin errors++; $display("FAIL br_after got %b exp %b", outs_b(), E_RUN); end
`ifdef HAZARD_PERF_EN
    checks++; if ({stall_count_a, flush_count_a} !== {16'd4, 16'd2}) begin errors++; $display("FAIL br_perf got %h exp %h", {stall_count_a, flush_count_a}, {16'd4, 16'd2}); end
`endif
    next_cycle();
  endtask

  task automatic test_reset_mid_mul();
    drive(MUL, 3'd1, 3'd0, 1'b0, 3'd0, 1'b0, 1'b0);
    @(negedge clock);
    checks++; if (outs_a() !== E_MUL0) begin errors++; $display("FAIL rmul_start got %b exp %b", outs_a(), E_MUL0); end
    next_cycle();
    @(negedge clock);
    checks++; if (outs_a() !== E_MULB) begin errors++; $display("FAIL rmul_busy got %b exp %b", outs_a(), E_MULB); end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    idle();
    @(negedge clock);
    checks++; if (outs_a() !== E_RUN) begin errors++; $display("FAIL rmul_after_a got %b exp %b", outs_a(), E_RUN); end
    checks++; if (outs_b() !== E_RUN) begin errors++; $display("FAIL rmul_after_b got %b exp %b", outs_b(), E_RUN); end
`ifdef HAZARD_PERF_EN
    checks++; if ({stall_count_a, flush_count_a} !== 32'd0) begin errors++; $display("FAIL rmul_perf got %h exp 0", {stall_count_a, flush_count_a}); end
`endif
    next_cycle();
  endtask

  initial begin
    id_opcode = 4'h1;
    test_reset();
    test_no_hazard();
    test_load_use();
    test_mul();
    test_branch();
    test_reset_mid_mul();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
